fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, PC/address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, fetched instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_req  output  1  fetch request to instruction memory.
REQ-007 SHALL have port mem_addr  output  DATA_WIDTH  byte address of request.
REQ-008 SHALL have port mem_ack  input  1  one-cycle pulse; mem_rdata valid this cycle.
REQ-009 SHALL have port mem_rdata  input  INST_WIDTH  instruction returned by memory.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 SHALL have port redirect_pc  input  DATA_WIDTH  redirect target.
REQ-012 SHALL have port inst_valid  output  1  instruction available to decode.
REQ-013 SHALL have port inst_ready  input  1  decode accepts instruction.
REQ-014 SHALL have port inst_data  output  INST_WIDTH  head instruction.
REQ-015 SHALL have port inst_pc  output  DATA_WIDTH  PC of head instruction.
REQ-016 SHALL have port fetch_fault  output  1  misaligned redirect target held.

Function
REQ-017 SHALL implement states FETCH, WAIT_SPACE, FLUSH, FAULT.
REQ-018 SHALL keep at most one memory request outstanding; mem_req held with stable mem_addr until mem_ack (ack allowed in same cycle as req).
REQ-019 SHALL buffer returned instructions in a 2-entry FIFO of {pc, data}; inst_valid = FIFO non-empty; pop on inst_valid && inst_ready.
REQ-020 FETCH: mem_req=1, mem_addr=pc; on mem_ack push {pc, mem_rdata}, pc <= pc+4; go WAIT_SPACE if FIFO full after push and pop, else stay FETCH with next request in following cycle.
REQ-021 WAIT_SPACE: mem_req=0; go FETCH in the cycle after FIFO occupancy drops below 2.
REQ-022 Redirect in FETCH without same-cycle ack: flush FIFO, pc <= redirect_pc, go FLUSH; keep old request asserted until mem_ack, discard its data, then go FETCH.
REQ-023 Redirect in the same cycle as mem_ack: data discarded, FIFO flushed, next cycle request redirect_pc in FETCH.
REQ-024 Redirect in FLUSH: update pc again; still discard pending ack.
REQ-025 Redirect in WAIT_SPACE or FAULT: flush FIFO, pc <= redirect_pc, go FETCH next cycle.
REQ-026 Redirect with redirect_pc[1:0] != 0: flush FIFO, fetch_fault=1, go FAULT (after FLUSH drain if request outstanding); FAULT issues no requests until an aligned redirect, which clears fetch_fault.
REQ-027 Redirect same cycle as pop: flush wins; popped entry counts as consumed, no other entry survives.
REQ-028 pc+4 SHALL wrap modulo 2^DATA_WIDTH (all-ones-minus-3 -> 0).
REQ-029 inst_data/inst_pc SHALL remain stable while inst_valid && !inst_ready.

Reset
REQ-030 On reset: state=FETCH, pc=RESET_PC, FIFO empty, inst_valid=0, fetch_fault=0, mem_req=0 during reset, mem_req=1 with mem_addr=RESET_PC in first cycle after release.
REQ-031 Reset mid-request SHALL abandon the outstanding request; a mem_ack in the reset cycle is ignored.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, INST_BYTES=4, and the FIFO entry struct.
REQ-033 The FIFO SHALL be sub-module fetch_fifo (2 entries, push/pop/flush, full/empty).

Verification
REQ-034 Reset release, ack every cycle, inst_ready=1 -> addresses 0,4,8,12 fetched; inst_pc 0,4,8 in order, one per cycle.
REQ-035 inst_ready=0 for 6 cycles -> exactly 2 instructions buffered, mem_req=0 (WAIT_SPACE); ready=1 -> pc 0,4 delivered, fetch resumes at 8.
REQ-036 Redirect to 0x40 while request to 0x8 pending, ack 3 cycles later -> ack data discarded, next mem_addr=0x40, FIFO empty.
REQ-037 Redirect to 0x42 -> fetch_fault=1, mem_req=0; redirect to 0x80 -> fault clears, mem_addr=0x80.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next mem_addr=0x0; reset asserted during pending request -> mem_req=0, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller.
//   fetch_state_e : controller states
//   fetch_entry_t : one buffered instruction, {pc, data}
//   INST_BYTES    : PC increment per fetched instruction
// Entry fields are sized for the widest supported configuration (64-bit PC,
// 32-bit instruction); narrower configurations zero-extend into them.
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned PC_BITS    = 64;
    localparam int unsigned INST_BITS  = 32;

    typedef enum logic [1:0] {
        StFetch,
        StWaitSpace,
        StFlush,
        StFault
    } fetch_state_e;

    typedef struct packed {
        logic [PC_BITS-1:0]   pc;
        logic [INST_BITS-1:0] data;
    } fetch_entry_t;

    localparam int unsigned ENTRY_BITS = $bits(fetch_entry_t);

    // Instructions are 4-byte aligned; any set low bit is a bad target.
    function automatic logic misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO holding fetched {pc, data} entries.
//   clk, reset    : clock, synchronous active-high reset
//   push, wdata   : write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   flush         : empty the FIFO; wins over push and pop
//   rdata         : head entry
//   full, empty   : occupancy flags
//   count         : occupancy, 0..2
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ENTRY_BITS-1:0] wdata,
    output logic [ENTRY_BITS-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [ENTRY_BITS-1:0] mem_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 2'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one outstanding request at a time to
// instruction memory, buffers returned instructions in a 2-entry FIFO and
// hands them to decode. Redirects flush the buffer and retarget the PC; a
// misaligned redirect target parks the controller in a fault state.
//   clk, reset                  : clock, synchronous active-high reset
//   mem_req/mem_addr            : fetch request, held until mem_ack
//   mem_ack/mem_rdata           : one-cycle response
//   redirect_valid/redirect_pc  : branch/jump retarget
//   inst_valid/inst_ready       : decode handshake
//   inst_data/inst_pc           : head instruction and its PC
//   fetch_fault                 : misaligned redirect target held
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_fault
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;  // address of the request being drained
    logic                  fault_q, fault_d;

    logic                  push, pop, flush;
    logic                  fifo_full, fifo_empty;
    logic [1:0]            fifo_count;
    fetch_entry_t          wr_entry, head;
    logic                  redirect_bad;

    assign redirect_bad = misaligned(redirect_pc[1:0]);
    assign wr_entry     = '{pc: PC_BITS'(pc_q), data: INST_BITS'(mem_rdata)};
    assign inst_valid   = !fifo_empty;
    assign inst_data    = head.data[INST_WIDTH-1:0];
    assign inst_pc      = head.pc[DATA_WIDTH-1:0];
    assign pop          = inst_valid && inst_ready;
    assign fetch_fault  = fault_q;

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        fault_d    = fault_q;
        unique case (state_q)
            StFetch: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    fault_d = redirect_bad;
                    if (mem_ack) begin
                        state_d = redirect_bad ? StFault : StFetch;
                    end else begin
                        // Request stays on the bus until acked; remember its address.
                        state_d    = StFlush;
                        req_addr_d = pc_q;
                    end
                end else if (mem_ack) begin
                    pc_d = pc_q + DATA_WIDTH'(INST_BYTES);
                    // Push lands on an occupancy of 1: full unless decode pops now.
                    if (fifo_count == 2'd1 && !pop) state_d = StWaitSpace;
                end
            end
            StWaitSpace: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    fault_d = redirect_bad;
                    state_d = redirect_bad ? StFault : StFetch;
                end else if (pop) begin
                    state_d = StFetch;
                end
            end
            StFlush: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    fault_d = redirect_bad;
                end
                if (mem_ack) state_d = fault_d ? StFault : StFetch;
            end
            StFault: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (!redirect_bad) begin
                        fault_d = 1'b0;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_q;
        push     = 1'b0;
        flush    = redirect_valid;
        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                push    = mem_ack && !redirect_valid;
            end
            StFlush: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
            end
            StWaitSpace, StFault: begin
                mem_req = 1'b0;
            end
            default: mem_req = 1'b0;
        endcase
        if (reset) begin
            mem_req = 1'b0;
            push    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns the inverted low address word, so data identifies its PC.
    assign mem_rdata = ~mem_addr[31:0];

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [63:0] pc);
        logic [31:0] d;
        d = ~pc[31:0];
        return {32'h0, d};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        mem_ack = 1'b1;   // ack during reset must be ignored
        #1;
        check("reset_mem_req", 64'(mem_req), 64'd0);
        check("reset_valid", 64'(inst_valid), 64'd0);
        check("reset_fault", 64'(fetch_fault), 64'd0);
        tick();

        // Streaming: ack every cycle, decode always ready.
        reset = 1'b0;
        mem_ack = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("s0_req", 64'(mem_req), 64'd1);
        check("s0_addr", mem_addr, 64'h0);
        check("s0_valid", 64'(inst_valid), 64'd0);
        tick();
        check("s1_addr", mem_addr, 64'h4);
        check("s1_pc", inst_pc, 64'h0);
        check("s1_data", 64'(inst_data), data_of(64'h0));
        tick();
        check("s2_addr", mem_addr, 64'h8);
        check("s2_pc", inst_pc, 64'h4);
        tick();
        check("s3_addr", mem_addr, 64'hC);
        check("s3_pc", inst_pc, 64'h8);

        // Back-pressure: decode stalls six cycles.
        do_reset();
        mem_ack = 1'b1;
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("bp_req", 64'(mem_req), 64'd0);
        check("bp_valid", 64'(inst_valid), 64'd1);
        check("bp_pc_stable", inst_pc, 64'h0);
        check("bp_data_stable", 64'(inst_data), data_of(64'h0));
        inst_ready = 1'b1;
        tick();
        check("bp_resume_req", 64'(mem_req), 64'd1);
        check("bp_resume_addr", mem_addr, 64'h8);
        check("bp_pc1", inst_pc, 64'h4);
        tick();
        check("bp_pc2", inst_pc, 64'h8);

        // Redirect while the request to 0x8 is pending.
        do_reset();
        mem_ack = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0;
        check("rd_hold_req", 64'(mem_req), 64'd1);
        check("rd_hold_addr", mem_addr, 64'h8);
        check("rd_flushed", 64'(inst_valid), 64'd0);
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rd_new_addr", mem_addr, 64'h40);
        check("rd_empty", 64'(inst_valid), 64'd0);
        tick();
        check("rd_discarded", 64'(inst_valid), 64'd0);
        check("rd_addr_held", mem_addr, 64'h40);

        // Misaligned redirect: drain old request, then fault.
        redirect_valid = 1'b1;
        redirect_pc = 64'h42;
        tick();
        redirect_valid = 1'b0;
        check("flt_flag", 64'(fetch_fault), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("flt_no_req", 64'(mem_req), 64'd0);
        check("flt_flag_held", 64'(fetch_fault), 64'd1);
        tick();
        check("flt_still_idle", 64'(mem_req), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h80;
        tick();
        redirect_valid = 1'b0;
        check("flt_cleared", 64'(fetch_fault), 64'd0);
        check("flt_req", 64'(mem_req), 64'd1);
        check("flt_addr", mem_addr, 64'h80);

        // Redirect in the same cycle as ack: data dropped.
        mem_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        tick();
        check("ra_addr", mem_addr, 64'h100);
        check("ra_empty", 64'(inst_valid), 64'd0);

        // PC wrap at the top of the address space.
        mem_ack = 1'b0;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        check("wr_addr_top", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wr_addr_wrap", mem_addr, 64'h0);
        check("wr_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_data_top", 64'(inst_data), data_of(64'hFFFF_FFFF_FFFF_FFFC));
        tick();
        check("wr_pending", 64'(mem_req), 64'd1);

        // Reset while the request to 0x0 is pending; ack in reset cycle ignored.
        reset = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("rst_mid_req", 64'(mem_req), 64'd0);
        tick();
        reset = 1'b0;
        mem_ack = 1'b0;
        inst_ready = 1'b0;
        #1;
        check("rst_restart_req", 64'(mem_req), 64'd1);
        check("rst_restart_addr", mem_addr, 64'h0);
        check("rst_ack_ignored", 64'(inst_valid), 64'd0);
        check("rst_fault", 64'(fetch_fault), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
